cache_l1d: RTL and testbench
============================

CACHE_L1D -- requirements
Module: cache_l1d

Interface
REQ-001 Parameter S_INDEX, default 4, meaning log2 of set count (16 sets, direct-mapped).
REQ-002 Parameter S_OFFSET, default 5, meaning log2 of line bytes (32-byte / 256-bit line).
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  synchronous, active-low reset.
REQ-005 mem_address  input  32  CPU byte address; bits [4:0] select byte in line, [8:5] index, [31:9] tag.
REQ-006 mem_read / mem_write  input  1 each  CPU request strobes; held until mem_resp.
REQ-007 mem_byte_enable  input  4  byte lanes of the addressed 32-bit word for writes.
REQ-008 mem_wdata  input  32  write data; mem_rdata  output  32  read data, valid while mem_resp=1.
REQ-009 mem_resp  output  1  single-cycle completion pulse to CPU.
REQ-010 pmem_address  output  32  line-aligned address to the cacheline adaptor; bits [4:0]=0.
REQ-011 pmem_read / pmem_write  output  1 each  line request to the adaptor; held until pmem_resp.
REQ-012 pmem_wdata  output  256  victim line; pmem_rdata  input  256  fill line; pmem_resp  input  1  adaptor done pulse.

Function
REQ-013 States: IDLE, COMPARE, WRITEBACK, ALLOCATE, encoded as a shared enum.
REQ-014 IDLE: on mem_read|mem_write, latch address, byte enables, wdata and operation; go to COMPARE next cycle.
REQ-015 COMPARE hit (valid & tag match): assert mem_resp for exactly that cycle; return to IDLE. A request arriving in cycle N yields mem_resp in cycle N+1.
REQ-016 Read hit: mem_rdata = word at latched address [4:2] of the line.
REQ-017 Write hit: merge mem_wdata into the selected word per byte enable; set dirty; byte_enable=0 still responds and still sets dirty.
REQ-018 COMPARE miss with victim valid & dirty: go to WRITEBACK; otherwise go to ALLOCATE.
REQ-019 WRITEBACK: pmem_write=1, pmem_address={victim tag, index, 5'b0}, pmem_wdata=victim line, all stable until pmem_resp; then ALLOCATE.
REQ-020 ALLOCATE: pmem_read=1, pmem_address={latched tag, index, 5'b0} until pmem_resp; on pmem_resp, write line, set valid, clear dirty, load tag; go to COMPARE (guaranteed hit).
REQ-021 pmem_read and pmem_write are never simultaneously 1; both are 0 in IDLE and COMPARE.
REQ-022 mem_read and mem_write both 1: treated as write.
REQ-023 CPU inputs are ignored outside IDLE; latched copies are used throughout the miss.
REQ-024 mem_resp is 0 in every state except a COMPARE hit.

Reset
REQ-025 While reset_n=0 on a clock edge: state=IDLE, all valid and dirty bits cleared; data and tag arrays are not reset.
REQ-026 Outputs during and after reset: mem_resp=0, pmem_read=0, pmem_write=0, mem_rdata=0; reset during WRITEBACK/ALLOCATE abandons the transfer with no response.

Configuration
REQ-027 Macro CACHE_L1D_PERF_EN: when defined, adds outputs hit_count and miss_count (32-bit each, reset to 0, wrapping at 2^32); hit_count increments on each COMPARE hit that responds, miss_count once per COMPARE miss (not on the post-fill re-compare).
REQ-028 Without CACHE_L1D_PERF_EN the ports and counters do not exist; all other behaviour is identical.

Structure
REQ-029 Package cache_l1d_pkg holds the state enum, S_INDEX/S_OFFSET defaults, derived tag width and line width constants.
REQ-030 One sub-module cache_l1d_array: parameterized width x sets storage with synchronous write, asynchronous read, per-byte write enable; instantiated for data (256b, 32 byte enables), tag (23b), valid and dirty (1b).

Verification
REQ-031 Cold read 0x0000_0040 -> ALLOCATE with pmem_address 0x0000_0040; after pmem_resp, mem_resp with word 0 of the fill line.
REQ-032 Repeat read 0x0000_0044 -> mem_resp exactly one cycle after request, no pmem activity, word 1 returned.
REQ-033 Write 0xDEADBEEF, byte_enable 4'b0011 to 0x0000_0040, then read -> returns {old[31:16],16'hBEEF}; dirty set.
REQ-034 Read 0x0000_0240 (same index 2, new tag) -> WRITEBACK at 0x0000_0040 with merged line, then ALLOCATE at 0x0000_0240, then mem_resp.
REQ-035 reset_n=0 while pmem_read=1 -> next cycle pmem_read=0, mem_resp=0; subsequent read of 0x0000_0040 misses.
REQ-036 With CACHE_L1D_PERF_EN, sequence REQ-031..034 -> hit_count=3, miss_count=2.

Source files
------------

// File: rtl/cache_l1d_pkg.sv
// cache_l1d shared types and geometry defaults.
// Optional perf counters: define CACHE_L1D_PERF_EN.
package cache_l1d_pkg;

  localparam int DEF_S_INDEX  = 4;
  localparam int DEF_S_OFFSET = 5;
  localparam int DEF_TAG_W    = 32 - DEF_S_INDEX - DEF_S_OFFSET;
  localparam int DEF_LINE_W   = 8 << DEF_S_OFFSET;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COMPARE   = 2'd1,
    WRITEBACK = 2'd2,
    ALLOCATE  = 2'd3
  } state_e;

endpackage

// File: rtl/cache_l1d_array.sv
// Set-indexed storage: sync byte-masked write, async read.
// Optional synchronous clear of every entry.
module cache_l1d_array #(
  parameter int WIDTH   = 1,
  parameter int S_INDEX = 4,
  parameter int BE_W    = (WIDTH + 7) / 8
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [S_INDEX-1:0] addr,
  input  logic [BE_W-1:0]    we,
  input  logic [WIDTH-1:0]   wdata,
  output logic [WIDTH-1:0]   rdata
);

  localparam int SETS = 2 ** S_INDEX;

  logic [WIDTH-1:0] mem [SETS];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int s = 0; s < SETS; s++) mem[s] <= '0;
    end else begin
      for (int b = 0; b < WIDTH; b++)
        if (we[b/8]) mem[addr][b] <= wdata[b];
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/cache_l1d.sv
// Direct-mapped write-back L1 data cache, one line per set.
// Optional hit/miss counters: define CACHE_L1D_PERF_EN.
module cache_l1d
  import cache_l1d_pkg::*;
#(
  parameter int S_INDEX  = DEF_S_INDEX,
  parameter int S_OFFSET = DEF_S_OFFSET
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [31:0]               mem_address,
  input  logic                      mem_read,
  input  logic                      mem_write,
  input  logic [3:0]                mem_byte_enable,
  input  logic [31:0]               mem_wdata,
  output logic [31:0]               mem_rdata,
  output logic                      mem_resp,
  output logic [31:0]               pmem_address,
  output logic                      pmem_read,
  output logic                      pmem_write,
  output logic [(8<<S_OFFSET)-1:0]  pmem_wdata,
  input  logic [(8<<S_OFFSET)-1:0]  pmem_rdata,
  input  logic                      pmem_resp
`ifdef CACHE_L1D_PERF_EN
  ,
  output logic [31:0]               hit_count,
  output logic [31:0]               miss_count
`endif
);

  localparam int TW = 32 - S_INDEX - S_OFFSET;
  localparam int LW = 8 << S_OFFSET;
  localparam int LB = LW / 8;
  localparam int WB = S_OFFSET - 2;

  state_e state_q, state_d;

  logic [31:0]        addr_q;
  logic [31:0]        wdata_q;
  logic [3:0]         be_q;
  logic               write_q;

  logic [S_INDEX-1:0] idx;
  logic [TW-1:0]      tag;
  logic [WB-1:0]      word;
  logic               unused_lo;

  assign idx       = addr_q[S_OFFSET +: S_INDEX];
  assign tag       = addr_q[31 -: TW];
  assign word      = addr_q[S_OFFSET-1:2];
  assign unused_lo = ^addr_q[1:0];

  logic [LW-1:0] data_rd, data_wd;
  logic [LB-1:0] data_we;
  logic [TW-1:0] tag_rd;
  logic          tag_we;
  logic          valid_rd, valid_we, valid_wd;
  logic          dirty_rd, dirty_we, dirty_wd;
  logic          hit;

  logic          resp_c, pread_c, pwrite_c;
  logic [31:0]   paddr_c;

  assign hit = valid_rd & (tag_rd == tag);

  cache_l1d_array #(.WIDTH(LW), .S_INDEX(S_INDEX)) u_data (
    .clk(clk), .clr(1'b0), .addr(idx),
    .we(data_we), .wdata(data_wd), .rdata(data_rd)
  );

  cache_l1d_array #(.WIDTH(TW), .S_INDEX(S_INDEX)) u_tag (
    .clk(clk), .clr(1'b0), .addr(idx),
    .we({((TW+7)/8){tag_we}}), .wdata(tag), .rdata(tag_rd)
  );

  cache_l1d_array #(.WIDTH(1), .S_INDEX(S_INDEX)) u_valid (
    .clk(clk), .clr(!reset_n), .addr(idx),
    .we(valid_we), .wdata(valid_wd), .rdata(valid_rd)
  );

  cache_l1d_array #(.WIDTH(1), .S_INDEX(S_INDEX)) u_dirty (
    .clk(clk), .clr(!reset_n), .addr(idx),
    .we(dirty_we), .wdata(dirty_wd), .rdata(dirty_rd)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && (mem_read || mem_write)) begin
        addr_q  <= mem_address;
        wdata_q <= mem_wdata;
        be_q    <= mem_byte_enable;
        write_q <= mem_write;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    resp_c   = 1'b0;
    pread_c  = 1'b0;
    pwrite_c = 1'b0;
    paddr_c  = {tag, idx, {S_OFFSET{1'b0}}};
    data_we  = '0;
    data_wd  = {(LW/32){wdata_q}};
    tag_we   = 1'b0;
    valid_we = 1'b0;
    valid_wd = 1'b1;
    dirty_we = 1'b0;
    dirty_wd = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (mem_read || mem_write) state_d = COMPARE;
      end
      COMPARE: begin
        if (hit) begin
          resp_c  = 1'b1;
          state_d = IDLE;
          if (write_q) begin
            data_we  = LB'(be_q) << {word, 2'b00};
            dirty_we = 1'b1;
          end
        end else if (valid_rd && dirty_rd) begin
          state_d = WRITEBACK;
        end else begin
          state_d = ALLOCATE;
        end
      end
      WRITEBACK: begin
        pwrite_c = 1'b1;
        paddr_c  = {tag_rd, idx, {S_OFFSET{1'b0}}};
        if (pmem_resp) state_d = ALLOCATE;
      end
      ALLOCATE: begin
        pread_c = 1'b1;
        if (pmem_resp) begin
          data_we  = '1;
          data_wd  = pmem_rdata;
          tag_we   = 1'b1;
          valid_we = 1'b1;
          dirty_we = 1'b1;
          dirty_wd = 1'b0;
          state_d  = COMPARE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset forces every handshake low even before the state register clears.
  assign mem_resp     = reset_n & resp_c;
  assign pmem_read    = reset_n & pread_c;
  assign pmem_write   = reset_n & pwrite_c;
  assign pmem_address = paddr_c;
  assign pmem_wdata   = data_rd;
  assign mem_rdata    = mem_resp ? data_rd[32*word +: 32] : 32'd0;

`ifdef CACHE_L1D_PERF_EN
  logic fill_q;

  // The compare right after a fill is not a new request.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fill_q     <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      fill_q <= (state_q == ALLOCATE);
      if (state_q == COMPARE && hit && !fill_q)
        hit_count <= hit_count + 32'd1;
      if (state_q == COMPARE && !hit)
        miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_l1d.sv
// Directed self-checking bench for cache_l1d.
// Perf counter checks active when CACHE_L1D_PERF_EN is defined.
module tb_cache_l1d;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [31:0]  mem_address;
  logic         mem_read, mem_write;
  logic [3:0]   mem_byte_enable;
  logic [31:0]  mem_wdata, mem_rdata;
  logic         mem_resp;
  logic [31:0]  pmem_address;
  logic         pmem_read, pmem_write;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;
`ifdef CACHE_L1D_PERF_EN
  logic [31:0]  hit_count, miss_count;
`endif

  cache_l1d dut (
    .clk(clk), .reset_n(reset_n),
    .mem_address(mem_address), .mem_read(mem_read),
    .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_resp(mem_resp), .pmem_address(pmem_address),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata),
    .pmem_resp(pmem_resp)
`ifdef CACHE_L1D_PERF_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  int           alloc_count = 0;
  int           wb_count = 0;
  logic [31:0]  alloc_addr = '0;
  logic [31:0]  wb_addr = '0;
  logic [255:0] wb_data = '0;
  logic         both_seen = 1'b0;
  logic         resp_en = 1'b1;
  int           wcnt = 0;

  function automatic logic [255:0] fill_line(input logic [31:0] a);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = {8'h5A, a[15:0], 8'(w)};
    return l;
  endfunction

  // Adaptor model: answers each line request after three cycles.
  always @(negedge clk) begin
    if (pmem_read && pmem_write) both_seen = 1'b1;
    if (resp_en && (pmem_read || pmem_write)) begin
      if (wcnt == 2) begin
        pmem_resp = 1'b1;
        wcnt = 0;
        if (pmem_write) begin
          wb_count++;
          wb_addr = pmem_address;
          wb_data = pmem_wdata;
        end else begin
          alloc_count++;
          alloc_addr = pmem_address;
          pmem_rdata = fill_line(pmem_address);
        end
      end else begin
        pmem_resp = 1'b0;
        wcnt++;
      end
    end else begin
      pmem_resp = 1'b0;
      wcnt = 0;
    end
  end

  task automatic check(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic access(input logic rd, input logic wr,
                        input logic [31:0] a, input logic [3:0] be,
                        input logic [31:0] wd,
                        output logic [31:0] rdata, output int n);
    mem_read = rd;
    mem_write = wr;
    mem_address = a;
    mem_byte_enable = be;
    mem_wdata = wd;
    n = 0;
    rdata = 'x;
    while (n < 60) begin
      @(negedge clk);
      n++;
      if (mem_resp) begin
        rdata = mem_rdata;
        break;
      end
    end
    if (n >= 60) check("timeout", 1'b0, 1'b1);
    mem_read = 1'b0;
    mem_write = 1'b0;
    @(negedge clk);
  endtask

  logic [31:0]  rd;
  int           n;
  logic [255:0] exp_line;
  int           i;

  initial begin
    reset_n = 1'b0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    mem_address = '0;
    mem_byte_enable = '0;
    mem_wdata = '0;
    pmem_rdata = '0;
    pmem_resp = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_resp", mem_resp, 1'b0);
    check("rst_pread", pmem_read, 1'b0);
    check("rst_pwrite", pmem_write, 1'b0);
    check("rst_rdata", mem_rdata, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    access(1, 0, 32'h40, 4'h0, 0, rd, n);
    check("cold_alloc_cnt", alloc_count, 1);
    check("cold_alloc_addr", alloc_addr, 32'h40);
    check("cold_wb_cnt", wb_count, 0);
    check("cold_rdata", rd, 32'h5A00_4000);
    check("cold_slow", n > 1, 1'b1);

    access(1, 0, 32'h44, 4'h0, 0, rd, n);
    check("hit_latency", n, 1);
    check("hit_rdata", rd, 32'h5A00_4001);
    check("hit_no_pmem", alloc_count, 1);

    access(0, 1, 32'h40, 4'b0011, 32'hDEAD_BEEF, rd, n);
    check("wr_latency", n, 1);
    access(1, 0, 32'h40, 4'h0, 0, rd, n);
    check("wr_merge", rd, 32'h5A00_BEEF);

    access(1, 0, 32'h240, 4'h0, 0, rd, n);
    exp_line = fill_line(32'h40);
    exp_line[31:0] = 32'h5A00_BEEF;
    check("evict_wb_cnt", wb_count, 1);
    check("evict_wb_addr", wb_addr, 32'h40);
    check("evict_wb_data", wb_data, exp_line);
    check("evict_alloc_cnt", alloc_count, 2);
    check("evict_alloc_addr", alloc_addr, 32'h240);
    check("evict_rdata", rd, 32'h5A02_4000);
`ifdef CACHE_L1D_PERF_EN
    check("perf_hits", hit_count, 32'd3);
    check("perf_misses", miss_count, 32'd2);
`endif

    resp_en = 1'b0;
    mem_read = 1'b1;
    mem_address = 32'h440;
    i = 0;
    while (i < 20 && !pmem_read) begin
      @(negedge clk);
      i++;
    end
    check("mid_alloc_seen", pmem_read, 1'b1);
    reset_n = 1'b0;
    mem_read = 1'b0;
    @(negedge clk);
    check("abort_pread", pmem_read, 1'b0);
    check("abort_resp", mem_resp, 1'b0);
    check("abort_rdata", mem_rdata, 32'h0);
    reset_n = 1'b1;
    resp_en = 1'b1;
    @(negedge clk);
`ifdef CACHE_L1D_PERF_EN
    check("perf_rst_hits", hit_count, 32'd0);
`endif

    access(1, 0, 32'h40, 4'h0, 0, rd, n);
    check("post_rst_alloc", alloc_count, 3);
    check("post_rst_addr", alloc_addr, 32'h40);
    check("post_rst_no_wb", wb_count, 1);
    check("post_rst_rdata", rd, 32'h5A00_4000);

    access(0, 1, 32'h44, 4'b0000, 32'hFFFF_FFFF, rd, n);
    check("be0_latency", n, 1);
    access(1, 0, 32'h240, 4'h0, 0, rd, n);
    check("be0_dirty_wb", wb_count, 2);
    check("be0_wb_addr", wb_addr, 32'h40);
    check("be0_wb_data", wb_data, fill_line(32'h40));
    check("be0_rdata", rd, 32'h5A02_4000);

    access(1, 1, 32'h248, 4'hF, 32'h1234_5678, rd, n);
    check("rw_latency", n, 1);
    access(1, 0, 32'h248, 4'h0, 0, rd, n);
    check("rw_as_write", rd, 32'h1234_5678);

    check("no_overlap", both_seen, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
